// File: rtl/iir_wb_sampler.sv
// iir_wb_sampler
//   Wishbone master that drives the iir_wishbone filter peripheral from a
//   valid/ready sample stream. For every accepted sample it writes x to
//   ADDR_X, leaves the bus idle for SETTLE_CYCLES cycles, reads y from ADDR_Y
//   and presents y on the output stream.
// Ports
//   wb_clk_i, wb_rst_ni          clock (rising edge), async active-low reset
//   s_data_i/s_valid_i/s_ready_o input sample stream (signed x)
//   m_data_o/m_valid_o/m_ready_i output result stream (y)
//   wbm_*                        Wishbone master interface
//   err_o, clr_err_i             sticky transfer-timeout flag and its clear
//   done_cnt_o                   completed samples, wraps at 16 bits
module iir_wb_sampler #(
    parameter int unsigned                 DATA_WIDTH    = 32,
    parameter int unsigned                 ADDR_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0]       ADDR_X        = 'h3C,
    parameter logic [ADDR_WIDTH-1:0]       ADDR_Y        = 'h40,
    parameter int unsigned                 SETTLE_CYCLES = 2,
    parameter int unsigned                 TIMEOUT       = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    output logic                  err_o,
    input  logic                  clr_err_i,
    output logic [15:0]           done_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        SETTLE,
        RD,
        OUT
    } state_t;

    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t      state;
    logic [15:0] timer;
    logic [15:0] settle_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            s_ready_o  <= 1'b1;
            m_data_o   <= '0;
            m_valid_o  <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            err_o      <= 1'b0;
            done_cnt_o <= '0;
            timer      <= '0;
            settle_cnt <= '0;
        end else begin
            // A timeout later in this block overrides the clear (set wins).
            if (clr_err_i) begin
                err_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s_valid_i && s_ready_o) begin
                        wbm_dat_o <= s_data_i;
                        s_ready_o <= 1'b0;
                        timer     <= '0;
                        state     <= WR;
                    end
                end

                WR: begin
                    // First WR cycle launches the write; strobe rises one
                    // edge after the accept.
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= ADDR_X;
                        timer     <= '0;
                    end else if (wbm_ack_i) begin
                        wbm_we_o <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            // No settle gap: chain the read straight onto
                            // the write so latency stays 5+SETTLE_CYCLES.
                            wbm_adr_o <= ADDR_Y;
                            timer     <= '0;
                            state     <= RD;
                        end else begin
                            wbm_cyc_o  <= 1'b0;
                            wbm_stb_o  <= 1'b0;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                        s_ready_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= ADDR_Y;
                        timer     <= '0;
                        state     <= RD;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end

                RD: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        m_data_o  <= wbm_dat_i;
                        m_valid_o <= 1'b1;
                        state     <= OUT;
                    end else if (timer == TIMER_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        err_o     <= 1'b1;
                        s_ready_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                OUT: begin
                    if (m_ready_i) begin
                        m_valid_o  <= 1'b0;
                        done_cnt_o <= done_cnt_o + 16'd1;
                        s_ready_o  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
